// File: rtl/ripple_mon_pkg.sv
// ripple_mon_pkg: shared state encoding, default sizes and modular delta helper for ripple_count_monitor
package ripple_mon_pkg;
  typedef enum logic {IDLE, COUNT} state_t;
  localparam int CNT_W_DEF = 4;
  localparam int ACC_W_DEF = 16;
  localparam int WINDOW_DEF = 256;
  function automatic logic [31:0] mod_delta(input logic [31:0] nw, input logic [31:0] pv, input int unsigned w);
    return (nw - pv) & ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/ripple_count_monitor_sync.sv
// sync_stabilizer: two-flop synchronizer plus a third stage; a sample is accepted once it has held for two cycles
module sync_stabilizer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         clear,
  input  logic [W-1:0] d_async,
  output logic [W-1:0] q_stable,
  output logic         accept
);
  logic [W-1:0] s1, s2, s3;
  logic [2:0] fill;
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      fill <= '0;
    end else begin
      s1 <= d_async;
      s2 <= s1;
      s3 <= s2;
      fill <= {fill[1:0], 1'b1};
    end
  end
  // reset zeros in the pipe are not real samples; hold off until s3 carries one
  assign accept = fill[2] && (s2 == s3);
  assign q_stable = s3;
endmodule

// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor: windowed increment counter for an async ripple count, reported over valid/ready
module ripple_count_monitor
  import ripple_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int WINDOW = WINDOW_DEF
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [CNT_W-1:0] q_in,
  input  logic             enable,
  output logic [CNT_W-1:0] cur_count,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [ACC_W-1:0] rpt_count,
  output logic             rpt_sat,
  output logic             rpt_missed
);
  localparam int WIN_W = $clog2(WINDOW);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  state_t state, state_n;
  logic counting, entering, accept, take, expire, restart, free, primed, sat, sat_n, missed;
  logic [CNT_W-1:0] q_stable, cur_reg, prev;
  logic [ACC_W-1:0] acc, acc_n, delta;
  logic [ACC_W:0] sum;
  logic [WIN_W-1:0] wcnt;

  sync_stabilizer #(.W(CNT_W)) u_sync (
    .clock(clock),
    .clear(clear),
    .d_async(q_in),
    .q_stable(q_stable),
    .accept(accept)
  );

  assign cur_count = accept ? q_stable : cur_reg;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = enable ? COUNT : IDLE;
  end

  always_comb begin
    counting = state == COUNT;
    entering = state == IDLE && enable;
  end

  assign take = counting && accept && primed;
  assign delta = take ? ACC_W'(mod_delta(32'(q_stable), 32'(prev), CNT_W)) : '0;
  assign sum = {1'b0, acc} + {1'b0, delta};
  assign acc_n = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
  assign sat_n = sat | sum[ACC_W];
  assign expire = counting && wcnt == WIN_W'(WINDOW - 1);
  assign restart = expire || !enable;
  // a same-cycle handshake frees the report slot for the expiring window
  assign free = !rpt_valid || rpt_ready;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cur_reg <= '0;
      prev <= '0;
      primed <= 1'b0;
      wcnt <= '0;
      acc <= '0;
      sat <= 1'b0;
      missed <= 1'b0;
      rpt_valid <= 1'b0;
      rpt_count <= '0;
      rpt_sat <= 1'b0;
      rpt_missed <= 1'b0;
    end else begin
      cur_reg <= cur_count;
      if (entering) begin
        wcnt <= '0;
        primed <= 1'b0;
      end else if (counting) begin
        if (accept) begin
          prev <= q_stable;
          primed <= 1'b1;
        end
        wcnt <= restart ? '0 : wcnt + 1'b1;
        acc <= restart ? '0 : acc_n;
        sat <= restart ? 1'b0 : sat_n;
      end
      if (expire && free) begin
        rpt_count <= acc_n;
        rpt_sat <= sat_n;
        rpt_missed <= missed;
        missed <= 1'b0;
        rpt_valid <= 1'b1;
      end else begin
        if (expire) missed <= 1'b1;
        if (rpt_valid && rpt_ready) rpt_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ripple_count_monitor.sv
// tb_ripple_count_monitor: directed scenarios with hand-computed window totals, WINDOW shortened to 32
module tb_ripple_count_monitor;
  logic clock = 1'b0;
  logic clear, enable, rpt_ready, enable2, ready2;
  logic [3:0] q_in, q2, cur_count, cur2;
  logic rpt_valid, rpt_sat, rpt_missed, v2, sat2, missed2;
  logic [15:0] rpt_count;
  logic [3:0] cnt2;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ripple_count_monitor #(.CNT_W(4), .ACC_W(16), .WINDOW(32)) dut (
    .clock(clock), .clear(clear), .q_in(q_in), .enable(enable), .cur_count(cur_count),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_count(rpt_count),
    .rpt_sat(rpt_sat), .rpt_missed(rpt_missed)
  );

  ripple_count_monitor #(.CNT_W(4), .ACC_W(4), .WINDOW(32)) dut_sat (
    .clock(clock), .clear(clear), .q_in(q2), .enable(enable2), .cur_count(cur2),
    .rpt_valid(v2), .rpt_ready(ready2), .rpt_count(cnt2),
    .rpt_sat(sat2), .rpt_missed(missed2)
  );

  task automatic ack;
    rpt_ready = 1'b1;
    @(negedge clock);
    rpt_ready = 1'b0;
  endtask

  task automatic test_reset;
    clear = 1'b0; enable = 1'b0; q_in = 4'd5; rpt_ready = 1'b0;
    enable2 = 1'b0; q2 = 4'd0; ready2 = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (cur_count !== 4'd0) begin errors++; $display("FAIL reset_cur: got %0d want 0", cur_count); end
    checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rpt_valid); end
    checks++; if (rpt_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", rpt_count); end
    checks++; if (rpt_sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", rpt_sat); end
    checks++; if (rpt_missed !== 1'b0) begin errors++; $display("FAIL reset_missed: got %b want 0", rpt_missed); end
  endtask

  task automatic test_sync_latency;
    clear = 1'b1; enable = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (cur_count !== 4'd0) begin errors++; $display("FAIL lat_early: got %0d want 0", cur_count); end
    @(negedge clock);
    checks++; if (cur_count !== 4'd5) begin errors++; $display("FAIL lat_3cyc: got %0d want 5", cur_count); end
  endtask

  task automatic test_first_report;
    for (int i = 0; i < 100 && rpt_valid !== 1'b1; i++) @(negedge clock);
    checks++; if (rpt_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", rpt_valid); end
    checks++; if (rpt_count !== 16'd0) begin errors++; $display("FAIL first_count: got %0d want 0", rpt_count); end
    checks++; if (rpt_sat !== 1'b0) begin errors++; $display("FAIL first_sat: got %b want 0", rpt_sat); end
    checks++; if (rpt_missed !== 1'b0) begin errors++; $display("FAIL first_missed: got %b want 0", rpt_missed); end
    ack();
  endtask

  task automatic test_wrap;
    logic [3:0] steps [4] = '{4'd15, 4'd0, 4'd1, 4'd2};
    q_in = 4'd14;
    for (int i = 0; i < 100 && rpt_valid !== 1'b1; i++) @(negedge clock);
    checks++; if (rpt_count !== 16'd9 || rpt_valid !== 1'b1) begin errors++; $display("FAIL step_5_14: got %0d valid %b want 9", rpt_count, rpt_valid); end
    ack();
    for (int k = 0; k < 4; k++) begin
      q_in = steps[k];
      repeat (4) @(negedge clock);
    end
    for (int i = 0; i < 100 && rpt_valid !== 1'b1; i++) @(negedge clock);
    checks++; if (rpt_count !== 16'd4 || rpt_valid !== 1'b1) begin errors++; $display("FAIL wrap_count: got %0d valid %b want 4", rpt_count, rpt_valid); end
    checks++; if (rpt_sat !== 1'b0) begin errors++; $display("FAIL wrap_sat: got %b want 0", rpt_sat); end
    ack();
  endtask

  task automatic test_glitch;
    q_in = 4'd3;
    repeat (4) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      q_in = i[0] ? 4'd3 : 4'd7;
      @(negedge clock);
    end
    checks++; if (cur_count !== 4'd3) begin errors++; $display("FAIL glitch_hold: got %0d want 3", cur_count); end
    q_in = 4'd9;
    for (int i = 0; i < 100 && rpt_valid !== 1'b1; i++) @(negedge clock);
    // 2->3 contributes 1, 3->9 contributes 6
    checks++; if (rpt_count !== 16'd7 || rpt_valid !== 1'b1) begin errors++; $display("FAIL glitch_count: got %0d valid %b want 7", rpt_count, rpt_valid); end
    checks++; if (cur_count !== 4'd9) begin errors++; $display("FAIL glitch_settle: got %0d want 9", cur_count); end
    ack();
  endtask

  task automatic test_back_to_back;
    q_in = 4'd12;
    for (int i = 0; i < 100 && rpt_valid !== 1'b1; i++) @(negedge clock);
    checks++; if (rpt_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", rpt_valid); end
    checks++; if (rpt_count !== 16'd3) begin errors++; $display("FAIL bp_count: got %0d want 3", rpt_count); end
    checks++; if (rpt_missed !== 1'b0) begin errors++; $display("FAIL bp_missed: got %b want 0", rpt_missed); end
    q_in = 4'd14;
    repeat (32) @(negedge clock);
    q_in = 4'd15;
    repeat (16) @(negedge clock);
    checks++; if (rpt_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b want 1", rpt_valid); end
    checks++; if (rpt_count !== 16'd3) begin errors++; $display("FAIL bp_hold_count: got %0d want 3", rpt_count); end
    checks++; if (rpt_missed !== 1'b0) begin errors++; $display("FAIL bp_hold_missed: got %b want 0", rpt_missed); end
    ack();
    checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL bp_drop: got %b want 0", rpt_valid); end
    for (int i = 0; i < 100 && rpt_valid !== 1'b1; i++) @(negedge clock);
    checks++; if (rpt_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid: got %b want 1", rpt_valid); end
    checks++; if (rpt_count !== 16'd1) begin errors++; $display("FAIL bp_next_count: got %0d want 1", rpt_count); end
    checks++; if (rpt_missed !== 1'b1) begin errors++; $display("FAIL bp_next_missed: got %b want 1", rpt_missed); end
    ack();
  endtask

  task automatic test_clear;
    q_in = 4'd2;
    for (int i = 0; i < 100 && rpt_valid !== 1'b1; i++) @(negedge clock);
    checks++; if (rpt_count !== 16'd3 || rpt_valid !== 1'b1) begin errors++; $display("FAIL pre_clear_count: got %0d valid %b want 3", rpt_count, rpt_valid); end
    repeat (10) @(negedge clock);
    q_in = 4'd5;
    repeat (8) @(negedge clock);
    clear = 1'b0;
    #1;
    checks++; if (cur_count !== 4'd0) begin errors++; $display("FAIL clr_cur: got %0d want 0", cur_count); end
    checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b want 0", rpt_valid); end
    checks++; if (rpt_count !== 16'd0) begin errors++; $display("FAIL clr_count: got %0d want 0", rpt_count); end
    checks++; if (rpt_sat !== 1'b0) begin errors++; $display("FAIL clr_sat: got %b want 0", rpt_sat); end
    checks++; if (rpt_missed !== 1'b0) begin errors++; $display("FAIL clr_missed: got %b want 0", rpt_missed); end
    @(negedge clock);
    clear = 1'b1;
    repeat (8) @(negedge clock);
    q_in = 4'd8;
    for (int i = 0; i < 100 && rpt_valid !== 1'b1; i++) @(negedge clock);
    checks++; if (rpt_valid !== 1'b1) begin errors++; $display("FAIL post_clr_valid: got %b want 1", rpt_valid); end
    checks++; if (rpt_count !== 16'd3) begin errors++; $display("FAIL post_clr_count: got %0d want 3", rpt_count); end
    checks++; if (rpt_missed !== 1'b0) begin errors++; $display("FAIL post_clr_missed: got %b want 0", rpt_missed); end
    ack();
  endtask

  task automatic test_saturation;
    enable2 = 1'b1;
    repeat (6) @(negedge clock);
    q2 = 4'd10;
    repeat (4) @(negedge clock);
    q2 = 4'd4;
    for (int i = 0; i < 100 && v2 !== 1'b1; i++) @(negedge clock);
    checks++; if (v2 !== 1'b1) begin errors++; $display("FAIL sat_valid: got %b want 1", v2); end
    checks++; if (cnt2 !== 4'd15) begin errors++; $display("FAIL sat_count: got %0d want 15", cnt2); end
    checks++; if (sat2 !== 1'b1) begin errors++; $display("FAIL sat_flag: got %b want 1", sat2); end
    checks++; if (missed2 !== 1'b0) begin errors++; $display("FAIL sat_missed: got %b want 0", missed2); end
  endtask

  initial begin
    test_reset();
    test_sync_latency();
    test_first_report();
    test_wrap();
    test_glitch();
    test_back_to_back();
    test_clear();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ripple_count_monitor.md
# ripple_count_monitor

Synchronous consumer for the 4-bit asynchronous ripple counter output. It brings the ripple count into the system clock domain and filters out ripple-transition glitches. It converts successive stable samples into modulo-2^CNT_W increments and accumulates them over a fixed window of system clocks. Each window total is presented as a report on a valid/ready handshake. The block sits directly downstream of the ripple counter and feeds rate/event statistics to the control logic.

## Interface
- CNT_W, 4, width of the ripple count input
- ACC_W, 16, width of the accumulator and report count
- WINDOW, 256, measurement window length in clock cycles (≥ 8)
- clock  in  1  system clock; all state on rising edge
- clear  in  1  reset, asynchronous, active-low (0 = reset)
- q_in  in  CNT_W  raw ripple counter output, asynchronous to clock
- enable  in  1  1 = measure; 0 = hold window idle
- cur_count  out  CNT_W  latest stable, synchronized count
- rpt_valid  out  1  report available
- rpt_ready  in  1  consumer accepts report
- rpt_count  out  ACC_W  increments counted in the reported window, saturating
- rpt_sat  out  1  rpt_count saturated during that window
- rpt_missed  out  1  ≥1 window result was dropped since the previous accepted report

## Operation
- Synchronizer: two flops on q_in (s1, s2), then a third register s3. A sample is accepted only when s2 == s3, meaning it was stable for 2 consecutive cycles. Accepted values update cur_count.
- Baseline: the first accepted sample after reset or after an enable rise only sets prev and adds nothing (primed flag).
- Delta: on each later accepted sample, delta = (new − prev) mod 2^CNT_W, zero-extended to ACC_W, then prev ← new.
  - Input requirement: the ripple counter advances < 2^CNT_W increments between accepted samples. Faster input aliases; this is not detected.
- Accumulator: acc ← acc + delta.
  - Saturation: if the sum exceeds 2^ACC_W−1, acc stays at 2^ACC_W−1 and the sat flag is set.
- FSM states:
  - IDLE → COUNT when enable=1. Window counter is cleared and primed is cleared.
  - COUNT → COUNT each cycle, with window counter +1.
  - COUNT → IDLE when enable=0. acc, sat and window are cleared; a pending report is kept.
- Window expiry (window counter == WINDOW−1 in COUNT):
  - If no report is pending: the report registers load acc, including that cycle's delta, and sat. rpt_missed loads the missed flag, which is then cleared. rpt_valid ← 1.
  - If a report is pending: the result is dropped and the missed flag is set.
  - In both cases acc, sat and the window counter restart at 0 the next cycle, with no lost cycle. prev and primed are kept.
- Handshake:
  - rpt_valid stays high until the cycle with rpt_valid & rpt_ready. It drops the next cycle.
  - rpt_* are stable while valid.
  - If the handshake and a window expiry occur in the same cycle, the new result loads (not dropped) and rpt_valid stays 1.

## Timing
- Reset (clear=0), all outputs and state go to 0 immediately: cur_count=0, rpt_valid=0, rpt_count=0, rpt_sat=0, rpt_missed=0, FSM=IDLE, primed=0.
- Latency from a q_in change to accepted: 3 cycles, i.e. it appears in cur_count on the 3rd rising edge after the change settles.
- Latency to acc: +1 cycle.
- rpt_valid rises 1 cycle after the expiry edge.
- A report covers exactly WINDOW consecutive COUNT cycles of accepted samples.
- clear asserted mid-window or mid-handshake: everything is discarded with no partial report.

## Structure
- Package ripple_mon_pkg holds:
  - the state enum (IDLE, COUNT);
  - default CNT_W/ACC_W/WINDOW constants;
  - a mod-2^CNT_W delta function.
- Sub-module sync_stabilizer(clock, clear, d_async, q_stable, accept): the 2-flop sync plus the stability compare, parameterized by width.
- Top: FSM, window counter, accumulator, report register, handshake.

## Test plan
- Reset, then q_in held at 5 with enable=1: cur_count=5 after 3 cycles. The first report after WINDOW cycles has rpt_count=0, rpt_sat=0, rpt_missed=0.
- q_in steps 14→15→0→1→2, each held 4 cycles → rpt_count=4 (wrap handled).
- q_in changes every cycle through a glitch pattern (3,7,3,7…) and then settles at 9 from prev=3 → only stable samples count; delta=6.
- ACC_W=4 with 20 increments in a window → rpt_count=15, rpt_sat=1.
- rpt_ready held 0 for 2.5 windows, then 1:
  - the first report is kept, with rpt_missed=0;
  - the second window is dropped;
  - the next report has rpt_missed=1.
- clear pulsed low mid-window with rpt_valid=1 → all outputs 0 at once. After release, the next report counts only post-reset increments.
